// File: rtl/pc_attack_controller.sv
// pc_attack_controller: computer-side attack sequencer for the PC turn.
// A rising edge on pc_turn starts one attack. The sequencer picks an untried
// player cell, first pseudo-randomly from an 8-bit LFSR and then by a linear
// scan, reads it, writes back hit/miss and tracks the remaining ship cells.
//
// Board port handshake: board_rd_en is a one-cycle request and board_rd_data
// is consumed in the following cycle (no stall). board_wr_en is a one-cycle
// write strobe qualified by board_addr/board_wr_data. The two strobes are
// never high together, and board_addr holds its value between strobes.
module pc_attack_controller #(
  parameter int         CELLS     = 25,
  parameter int         ADDR_W    = 5,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_turn,
  input  logic              load_cells,
  input  logic [ADDR_W-1:0] cells_init,
  output logic              board_rd_en,
  output logic [ADDR_W-1:0] board_addr,
  input  logic [1:0]        board_rd_data,
  output logic              board_wr_en,
  output logic [1:0]        board_wr_data,
  output logic              pc_has_move,
  output logic              last_hit,
  output logic              board_full,
  output logic              player_ships_zero,
  output logic              busy,
  output logic [2:0]        dbg_state_o
);

  localparam int                TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W + 1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [TRY_W-1:0]  TRY_LIMIT = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    READ  = 3'd2,
    EVAL  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        lfsr_q;
  logic              pc_turn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        wr_data_q;
  logic              last_hit_q;
  logic              full_q;
  logic [ADDR_W-1:0] count_q;
  logic              loaded_q;
  logic [TRY_W-1:0]  tries_q;
  logic              scan_q;
  logic [ADDR_W-1:0] scan_ptr_q;

  logic              start;
  logic              tried;
  logic [TRY_W-1:0]  tries_inc;
  logic [ADDR_W-1:0] rand_addr;

  // Start detection, retry bookkeeping and folding of the LFSR value onto the board.
  always_comb begin
    start     = (state_q == IDLE) && pc_turn && !pc_turn_q;
    tried     = board_rd_data[1];
    tries_inc = tries_q + TRY_W'(1);
    rand_addr = lfsr_q[ADDR_W-1:0];
    if ({1'b0, lfsr_q[ADDR_W-1:0]} >= CELLS_W) begin
      rand_addr = lfsr_q[ADDR_W-1:0] - CELLS_W[ADDR_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: retries loop back to PICK, an exhausted scan skips the write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = PICK;
      PICK:  state_d = READ;
      READ:  state_d = EVAL;
      EVAL: begin
        if (!tried) begin
          state_d = WRITE;
        end else if (scan_q && (scan_ptr_q == LAST_CELL)) begin
          state_d = DONE;
        end else begin
          state_d = PICK;
        end
      end
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: LFSR, pick address, retry/scan tracking, result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= SEED;
      pc_turn_q  <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= 2'b00;
      last_hit_q <= 1'b0;
      full_q     <= 1'b0;
      tries_q    <= '0;
      scan_q     <= 1'b0;
      scan_ptr_q <= '0;
    end else begin
      // x^8+x^6+x^5+x^4+1, free-running in every state
      lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      pc_turn_q <= pc_turn;
      case (state_q)
        IDLE: begin
          if (start) begin
            tries_q    <= '0;
            scan_q     <= 1'b0;
            scan_ptr_q <= '0;
          end
        end
        PICK: addr_q <= scan_q ? scan_ptr_q : rand_addr;
        EVAL: begin
          if (!tried) begin
            // ship (01) becomes hit (11), water (00) becomes miss (10)
            wr_data_q <= {1'b1, board_rd_data[0]};
          end else if (!scan_q) begin
            tries_q <= tries_inc;
            if (tries_inc == TRY_LIMIT) begin
              scan_q     <= 1'b1;
              scan_ptr_q <= '0;
            end
          end else if (scan_ptr_q == LAST_CELL) begin
            full_q <= 1'b1;
          end else begin
            scan_ptr_q <= scan_ptr_q + ADDR_W'(1);
          end
        end
        WRITE: last_hit_q <= wr_data_q[0];
        default: ;
      endcase
    end
  end

  // Remaining player ship cells; a load wins over a same-cycle hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      loaded_q <= 1'b0;
    end else if (load_cells) begin
      count_q  <= cells_init;
      loaded_q <= 1'b1;
    end else if ((state_q == WRITE) && wr_data_q[0] && (count_q != '0)) begin
      count_q <= count_q - ADDR_W'(1);
    end
  end

  assign board_rd_en       = (state_q == READ);
  assign board_wr_en       = (state_q == WRITE);
  assign board_addr        = addr_q;
  assign board_wr_data     = wr_data_q;
  assign pc_has_move       = (state_q == DONE);
  assign last_hit          = last_hit_q;
  assign board_full        = full_q;
  assign player_ships_zero = loaded_q && (count_q == '0);
  assign busy              = (state_q != IDLE);
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_pc_attack_controller.sv
// Testbench for pc_attack_controller: behavioural board memory, an attack
// model that predicts every board read/write and completion pulse with its
// cycle, and a monitor that pops the expected queue whenever the DUT strobes.
module tb_pc_attack_controller;

  localparam int         CELLS     = 25;
  localparam int         ADDR_W    = 5;
  localparam int         MAX_TRIES = 8;
  localparam logic [7:0] SEED      = 8'hA5;
  localparam int         W         = 44;  // {cycle[31:0], kind[1:0], addr[4:0], data[1:0], flags[2:0]}
  localparam int         K_RD      = 1;
  localparam int         K_WR      = 2;
  localparam int         K_DN      = 3;

  logic              clk = 1'b0;
  logic              rst, pc_turn, load_cells;
  logic [ADDR_W-1:0] cells_init;
  logic              board_rd_en, board_wr_en;
  logic [ADDR_W-1:0] board_addr;
  logic [1:0]        board_rd_data, board_wr_data;
  logic              pc_has_move, last_hit, board_full, player_ships_zero, busy;
  logic [2:0]        dbg_state_o;

  logic [1:0]        mem[CELLS];
  logic [1:0]        mem_img[CELLS];
  logic              mem_load;

  logic [W-1:0]      exp_q[$];
  int                n_vec = 0;
  int                n_fail = 0;
  int                cyc = 0;
  logic [7:0]        lfsr_now;

  int                m_count;
  bit                m_loaded, m_last_hit, m_full;

  pc_attack_controller #(
    .CELLS(CELLS), .ADDR_W(ADDR_W), .SEED(SEED), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .rst(rst), .pc_turn(pc_turn), .load_cells(load_cells),
    .cells_init(cells_init), .board_rd_en(board_rd_en), .board_addr(board_addr),
    .board_rd_data(board_rd_data), .board_wr_en(board_wr_en),
    .board_wr_data(board_wr_data), .pc_has_move(pc_has_move), .last_hit(last_hit),
    .board_full(board_full), .player_ships_zero(player_ships_zero), .busy(busy),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // cycle counter and the LFSR value the polynomial gives for the current cycle
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    lfsr_now <= rst ? SEED : lfsr_step(lfsr_now);
  end

  // board memory: registered read, image load from the bench, DUT writes
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= mem_img[i];
    end else if (board_wr_en) begin
      mem[board_addr] <= board_wr_data;
    end
    if (board_rd_en) board_rd_data <= mem[board_addr];
  end

  function automatic logic [W-1:0] mk(input int c, input int kind, input int a,
                                      input int d, input logic [2:0] f);
    return {32'(c), 2'(kind), ADDR_W'(a), 2'(d), f};
  endfunction

  function automatic logic [2:0] flags();
    return {m_last_hit, m_full, m_loaded && (m_count == 0)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic compare_event(input logic [W-1:0] act);
    logic [W-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event (cyc,kind,addr,data,flags) got %h required none", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL board_event (cyc,kind,addr,data,flags) got %h required %h", act, e);
      end
    end
  endtask

  // monitor: every strobe the DUT presents is matched against the queue
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (board_rd_en && board_wr_en) begin
        n_vec++;
        n_fail++;
        $display("FAIL strobe_overlap got rd=1 wr=1 required at most one");
      end
      if (board_rd_en) compare_event(mk(cyc, K_RD, int'(board_addr), 0, 3'b000));
      if (board_wr_en) compare_event(mk(cyc, K_WR, int'(board_addr), int'(board_wr_data), 3'b000));
      if (pc_has_move) compare_event(mk(cyc, K_DN, 0, 0, {last_hit, board_full, player_ships_zero}));
    end
  endtask

  // driver: board image
  task automatic set_board(input logic [1:0] base, input int special, input logic [1:0] scode,
                           input bit rnd);
    for (int i = 0; i < CELLS; i++) begin
      if (rnd) mem_img[i] = ($urandom_range(0, 9) < 6) ? {1'b1, 1'($urandom_range(0, 1))}
                                                       : {1'b0, 1'($urandom_range(0, 1))};
      else     mem_img[i] = (i == special) ? scode : base;
    end
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
  endtask

  task automatic load(input int n);
    cells_init = ADDR_W'(n);
    load_cells = 1'b1;
    tick();
    load_cells = 1'b0;
    m_count    = n;
    m_loaded   = 1'b1;
  endtask

  // driver + reference model: raise pc_turn and predict the whole attack
  task automatic start_attack();
    logic [7:0] l;
    logic [1:0] code;
    int tries, ptr, k, addr, n;
    bit scan, fin;
    l = lfsr_now; n = cyc; tries = 0; ptr = 0; k = 0; scan = 0; fin = 0;
    pc_turn = 1'b1;
    while (!fin) begin
      // picks happen one cycle after the start edge, then every three cycles
      l = lfsr_step(l);
      if (k > 0) begin
        l = lfsr_step(l);
        l = lfsr_step(l);
      end
      if (scan) begin
        addr = ptr;
      end else begin
        addr = int'(l[ADDR_W-1:0]);
        if (addr >= CELLS) addr -= CELLS;
      end
      exp_q.push_back(mk(n + 2 + 3 * k, K_RD, addr, 0, 3'b000));
      code = mem[addr];
      if (code[1] == 1'b0) begin
        m_last_hit = code[0];
        if (code[0] && m_count > 0) m_count--;
        exp_q.push_back(mk(n + 4 + 3 * k, K_WR, addr, code[0] ? 3 : 2, 3'b000));
        exp_q.push_back(mk(n + 5 + 3 * k, K_DN, 0, 0, flags()));
        fin = 1;
      end else if (!scan) begin
        tries++;
        if (tries == MAX_TRIES) begin
          scan = 1;
          ptr  = 0;
        end
      end else if (ptr == CELLS - 1) begin
        m_full = 1'b1;
        exp_q.push_back(mk(n + 4 + 3 * k, K_DN, 0, 0, flags()));
        fin = 1;
      end else begin
        ptr++;
      end
      k++;
    end
  endtask

  task automatic wait_done(input int width);
    int c;
    c = 0;
    tick();
    c++;
    check("busy_running", busy, 1);
    if (c >= width) pc_turn = 1'b0;
    while ((exp_q.size() != 0 || c < width) && c < 400) begin
      tick();
      c++;
      if (c >= width) pc_turn = 1'b0;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL attack_timeout got %0d pending events required 0", exp_q.size());
      exp_q.delete();
    end
    pc_turn = 1'b0;
    tick();
    tick();
    check("busy_idle", busy, 0);
  endtask

  task automatic attack(input int width);
    start_attack();
    wait_done(width);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, board_rd_en, 0);
    check({tag, "_wr_en"}, board_wr_en, 0);
    check({tag, "_addr"}, board_addr, 0);
    check({tag, "_wr_data"}, board_wr_data, 0);
    check({tag, "_has_move"}, pc_has_move, 0);
    check({tag, "_last_hit"}, last_hit, 0);
    check({tag, "_board_full"}, board_full, 0);
    check({tag, "_ships_zero"}, player_ships_zero, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; pc_turn = 1'b0; load_cells = 1'b0; cells_init = '0; mem_load = 1'b0;
    m_count = 0; m_loaded = 0; m_last_hit = 0; m_full = 0;
    for (int i = 0; i < CELLS; i++) mem_img[i] = 2'b00;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // empty board: a miss, counter untouched
    set_board(2'b00, -1, 2'b00, 0);
    load(3);
    attack(3);
    check("ships_zero_after_miss", player_ships_zero, 0);

    // all ship cells, one ship cell left: hit drives ships_zero with the pulse
    set_board(2'b01, -1, 2'b00, 0);
    load(1);
    attack(2);
    check("last_hit_after_hit", last_hit, 1);

    // only the last cell untried: random retries then the scan finds it
    set_board(2'b10, CELLS - 1, 2'b00, 0);
    attack(1);

    // nothing untried: scan exhausts and reports a full board
    set_board(2'b11, 3, 2'b10, 0);
    attack(4);
    check("board_full_held", board_full, 1);

    // level held high gives one attack; a new rising edge gives another
    set_board(2'b00, 7, 2'b01, 0);
    attack(50);
    attack(2);

    // randomized boards, pulse widths and ship counts
    for (int t = 0; t < 14; t++) begin
      set_board(2'b00, -1, 2'b00, 1);
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, CELLS));
      attack($urandom_range(1, 8));
    end

    // reset in the first EVAL: sequence dropped, state back to reset values
    set_board(2'b00, -1, 2'b00, 1);
    load(5);
    start_attack();
    tick();
    tick();
    tick();
    rst = 1'b1;
    pc_turn = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    m_count = 0; m_loaded = 0; m_last_hit = 0; m_full = 0;
    check_reset_outputs("mid_reset");
    repeat (4) tick();
    // next attack starts from the reset LFSR seed
    attack(2);

    // zero ship cells loaded
    load(0);
    check("ships_zero_on_load0", player_ships_zero, 1);
    load(2);
    check("ships_zero_on_load2", player_ships_zero, 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
